// File: rtl/fifo_pkg.sv
// Shared constants, helpers and the prefetch state type for the sample FIFO.
package fifo_pkg;

    localparam int DEF_DATA_SIZE     = 12;
    localparam int DEF_ADDR_SIZE     = 8;
    localparam int DEF_AFULL_MARGIN  = 4;
    localparam int DEF_AEMPTY_THRESH = 4;

    function automatic int fifo_depth(input int addr_size);
        return 32'sd1 << addr_size;
    endfunction

    // The level counter must represent DEPTH itself, hence one bit wider than a pointer.
    function automatic int level_width(input int addr_size);
        return addr_size + 32'sd1;
    endfunction

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fifo_ram_sync.sv
// Simple dual-port storage: one write port and a registered read port with read enable.
module fifo_ram_sync
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem_r [DEPTH];
    logic [DATA_SIZE-1:0] rdata_r;

    // Write port; contents are deliberately never cleared
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, only updated when a fetch is requested
    always_ff @(posedge clk_i) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sample_fifo.sv
// Sample FIFO: never-stalling write side, valid/ready first-word fall-through read side.
// Build option SAMPLE_FIFO_OVERWRITE_EN: a push into a full FIFO replaces the oldest sample.
module sample_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int ADDR_SIZE     = DEF_ADDR_SIZE,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_SIZE) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   w_en_i,
    input  logic [DATA_SIZE-1:0]   w_data_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [DATA_SIZE-1:0]   r_data_o,
    output logic [ADDR_SIZE:0]     level_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   almost_full_o,
    output logic                   almost_empty_o,
    output logic                   overflow_o
);

    localparam int LW    = level_width(ADDR_SIZE);
    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    localparam logic [LW-1:0]        LVL_ZERO   = {LW{1'b0}};
    localparam logic [LW-1:0]        LVL_ONE    = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]        LVL_DEPTH  = LW'(DEPTH);
    localparam logic [LW-1:0]        LVL_AFULL  = LW'(AFULL_THRESH);
    localparam logic [LW-1:0]        LVL_AEMPTY = LW'(AEMPTY_THRESH);
    localparam logic [ADDR_SIZE-1:0] PTR_ZERO   = {ADDR_SIZE{1'b0}};
    localparam logic [ADDR_SIZE-1:0] PTR_ONE    = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [ADDR_SIZE-1:0] wr_ptr_r;
    logic [ADDR_SIZE-1:0] rd_ptr_r;
    logic [LW-1:0]        level_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 afull_r;
    logic                 aempty_r;
    logic                 overflow_r;
    logic                 r_valid_r;
    logic [DATA_SIZE-1:0] r_data_r;
    fetch_state_e         state_r;

    logic                 flush_s;
    logic                 pop_s;
    logic                 lost_s;
    logic                 wr_s;
    logic                 ovw_s;
    logic                 ram_we_s;
    logic                 ram_re_s;
    logic                 load_s;
    logic [ADDR_SIZE-1:0] wr_ptr_nxt_s;
    logic [ADDR_SIZE-1:0] rd_ptr_nxt_s;
    logic [LW-1:0]        level_nxt_s;
    logic [DATA_SIZE-1:0] ram_rdata_s;
    fetch_state_e         state_nxt_s;

    // Push/pop qualification, pointer and level arithmetic
    always_comb begin
        flush_s = rst_i | clear_i;
        pop_s   = r_valid_r & r_ready_i;
        lost_s  = w_en_i & full_r & ~pop_s;
        wr_s    = w_en_i & ~lost_s;
`ifdef SAMPLE_FIFO_OVERWRITE_EN
        ovw_s   = lost_s;
`else
        ovw_s   = 1'b0;
`endif
        ram_we_s = (wr_s | ovw_s) & ~flush_s;
        if (wr_s | ovw_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s | ovw_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // An overwrite leaves the level at DEPTH, so it is neither +1 nor -1
        if (wr_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s && !wr_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Prefetch sequencing: issue a RAM read, then load the head register
    always_comb begin
        state_nxt_s = state_r;
        ram_re_s    = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (level_r != LVL_ZERO) begin
                    ram_re_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FETCH: begin
                // An overwrite during a fetch makes the in-flight word stale
                if (ovw_s) begin
                    ram_re_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_VALID;
                end
            end
            ST_VALID: begin
                if (ovw_s) begin
                    ram_re_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else if (pop_s) begin
                    // With a single word, a same-cycle push is re-fetched from empty
                    if (level_r > LVL_ONE) begin
                        ram_re_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end else begin
                    state_nxt_s = ST_VALID;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Prefetch state register
    always_ff @(posedge clk_i) begin
        if (flush_s) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, level, flags, overflow and the registered head word
    always_ff @(posedge clk_i) begin
        if (flush_s) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            afull_r    <= 1'b0;
            aempty_r   <= 1'b1;
            overflow_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_data_r   <= {DATA_SIZE{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            level_r    <= level_nxt_s;
            full_r     <= (level_nxt_s == LVL_DEPTH);
            empty_r    <= (level_nxt_s == LVL_ZERO);
            afull_r    <= (level_nxt_s >= LVL_AFULL);
            aempty_r   <= (level_nxt_s <= LVL_AEMPTY);
            overflow_r <= overflow_r | lost_s;
            r_valid_r  <= (state_nxt_s == ST_VALID);
            if (load_s) begin
                r_data_r <= ram_rdata_s;
            end
        end
    end

    fifo_ram_sync #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (w_data_i),
        .re    (ram_re_s & ~flush_s),
        .raddr (rd_ptr_nxt_s),
        .rdata (ram_rdata_s)
    );

    assign r_valid_o      = r_valid_r;
    assign r_data_o       = r_data_r;
    assign level_o        = level_r;
    assign full_o         = full_r;
    assign empty_o        = empty_r;
    assign almost_full_o  = afull_r;
    assign almost_empty_o = aempty_r;
    assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: queue-based reference model with a head-visibility delay.
// Honours SAMPLE_FIFO_OVERWRITE_EN in its model when the macro is defined for the build.
module tb_sample_fifo;

    localparam int DW     = 12;
    localparam int DEPTH  = 256;
    localparam int AFULL  = 252;
    localparam int AEMPTY = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, clear_i, w_en_i, r_ready_i;
    logic [DW-1:0] w_data_i;
    logic          r_valid_o, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o;
    logic [DW-1:0] r_data_o;
    logic [8:0]    level_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: stored words in order, head visibility and the sticky loss flag
    logic [DW-1:0] mq[$];
    bit            m_valid = 1'b0;
    int            m_wait  = 0;
    bit            m_ovf   = 1'b0;

    sample_fifo dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .w_en_i         (w_en_i),
        .w_data_i       (w_data_i),
        .r_valid_o      (r_valid_o),
        .r_ready_i      (r_ready_i),
        .r_data_o       (r_data_o),
        .level_o        (level_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // A new head becomes visible two edges after it is written into an empty FIFO,
    // one edge after a pop (or overwrite) exposes an already stored word.
    task automatic model_edge(input bit push, input logic [DW-1:0] d, input bit ready, input bit flush);
        bit pop;
        int n0;
        if (flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_wait  = 0;
            m_ovf   = 1'b0;
            return;
        end
        pop = m_valid && ready;
        n0  = mq.size();
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end
        if (pop) begin
            void'(mq.pop_front());
            m_valid = 1'b0;
            m_wait  = (n0 > 1) ? 1 : 0;
        end
        if (push) begin
            if (n0 == DEPTH && !pop) begin
                m_ovf = 1'b1;
`ifdef SAMPLE_FIFO_OVERWRITE_EN
                void'(mq.pop_front());
                mq.push_back(d);
                m_valid = 1'b0;
                m_wait  = 1;
`endif
            end else begin
                mq.push_back(d);
                if (mq.size() == 1) m_wait = 2;
            end
        end
    endtask

    task automatic step(input bit push, input logic [DW-1:0] d, input bit ready, input bit clr);
        w_en_i    = push;
        w_data_i  = d;
        r_ready_i = ready;
        clear_i   = clr;
        @(posedge clk_i);
        model_edge(push, d, ready, clr || rst_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step(1'b1, 12'hFFF, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (level_o !== 9'd0)        begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level_o); end
        n_chk++; if (r_valid_o !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", r_valid_o); end
        n_chk++; if (r_data_o !== 12'h000)    begin n_fail++; $display("FAIL reset_data: got %0h expected 0", r_data_o); end
        n_chk++; if (overflow_o !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", overflow_o); end
        n_chk++; if (empty_o !== 1'b1)        begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty_o); end
        n_chk++; if (full_o !== 1'b0)         begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full_o); end
        n_chk++; if (almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %0b expected 1", almost_empty_o); end
        n_chk++; if (almost_full_o !== 1'b0)  begin n_fail++; $display("FAIL reset_afull: got %0b expected 0", almost_full_o); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'(i + 1), 1'b0, 1'b0);
            n_chk++; if (r_valid_o !== (i >= 2)) begin n_fail++; $display("FAIL basic_valid[%0d]: got %0b expected %0b", i, r_valid_o, (i >= 2)); end
            if (i >= 2) begin
                n_chk++; if (r_data_o !== 12'h001) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h expected 001", i, r_data_o); end
            end
        end
        n_chk++; if (level_o !== 9'd4)        begin n_fail++; $display("FAIL basic_level: got %0d expected 4", level_o); end
        n_chk++; if (almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL basic_aempty: got %0b expected 1", almost_empty_o); end
        n_chk++; if (empty_o !== 1'b0)        begin n_fail++; $display("FAIL basic_empty: got %0b expected 0", empty_o); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_q[$];
        int idx;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 12'(i), 1'b0, 1'b0);
        n_chk++; if (full_o !== 1'b1)      begin n_fail++; $display("FAIL ovf_full_before: got %0b expected 1", full_o); end
        n_chk++; if (overflow_o !== 1'b0)  begin n_fail++; $display("FAIL ovf_flag_before: got %0b expected 0", overflow_o); end
        step(1'b1, 12'hABC, 1'b0, 1'b0);
        n_chk++; if (full_o !== 1'b1)      begin n_fail++; $display("FAIL ovf_full: got %0b expected 1", full_o); end
        n_chk++; if (overflow_o !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow_o); end
        n_chk++; if (level_o !== 9'd256)   begin n_fail++; $display("FAIL ovf_level: got %0d expected 256", level_o); end
`ifdef SAMPLE_FIFO_OVERWRITE_EN
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(12'(i));
        exp_q.push_back(12'hABC);
`else
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(12'(i));
`endif
        idx = 0;
        for (int c = 0; c < 1200 && mq.size() > 0; c++) begin
            if (m_valid) begin
                n_chk++;
                if (idx >= exp_q.size() || r_data_o !== exp_q[idx]) begin
                    n_fail++; $display("FAIL ovf_drain[%0d]: got %0h expected %0h", idx, r_data_o, (idx < exp_q.size()) ? exp_q[idx] : 12'h000);
                end
                idx++;
            end
            step(1'b0, 12'h000, 1'b1, 1'b0);
            n_chk++; if (r_valid_o !== m_valid) begin n_fail++; $display("FAIL ovf_drain_valid: got %0b expected %0b", r_valid_o, m_valid); end
        end
        n_chk++; if (idx !== DEPTH)        begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected %0d", idx, DEPTH); end
        n_chk++; if (empty_o !== 1'b1)     begin n_fail++; $display("FAIL ovf_empty_after: got %0b expected 1", empty_o); end
        n_chk++; if (overflow_o !== 1'b1)  begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow_o); end
    endtask

    task automatic test_full_rw();
        int pops;
        bit pv;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 12'($urandom), 1'b0, 1'b0);
        pops = 0;
        // Push only on cycles that also pop, so the full FIFO never drops a sample
        for (int c = 0; c < 40 && pops < 10; c++) begin
            pv = m_valid;
            if (pv) begin
                n_chk++; if (r_data_o !== mq[0]) begin n_fail++; $display("FAIL fullrw_data[%0d]: got %0h expected %0h", pops, r_data_o, mq[0]); end
                pops++;
            end
            step(pv, 12'h5A5, 1'b1, 1'b0);
            n_chk++; if (level_o !== 9'd256)  begin n_fail++; $display("FAIL fullrw_level: got %0d expected 256", level_o); end
            n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL fullrw_ovf: got %0b expected 0", overflow_o); end
        end
        n_chk++; if (pops !== 10) begin n_fail++; $display("FAIL fullrw_pops: got %0d expected 10", pops); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] log_q[$];
        logic [DW-1:0] d;
        int pidx;
        bit pv, ps;
        do_reset();
        pidx = 0;
        // The read bubble limits sustained throughput to one word every two cycles
        for (int c = 0; c < 600; c++) begin
            pv = m_valid;
            ps = (c % 2 == 0);
            d  = 12'($urandom);
            if (pv) begin
                n_chk++;
                if (pidx >= log_q.size() || r_data_o !== log_q[pidx]) begin
                    n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", pidx, r_data_o, (pidx < log_q.size()) ? log_q[pidx] : 12'h000);
                end
                pidx++;
            end
            if (ps) log_q.push_back(d);
            step(ps, d, 1'b1, 1'b0);
            n_chk++; if (r_valid_o !== m_valid) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", c, r_valid_o, m_valid); end
        end
        n_chk++; if (overflow_o !== 1'b0)  begin n_fail++; $display("FAIL stream_ovf: got %0b expected 0", overflow_o); end
        n_chk++; if (pidx < DEPTH + 1)     begin n_fail++; $display("FAIL stream_wrap: got %0d pops expected at least %0d", pidx, DEPTH + 1); end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) step(1'b1, 12'(i), 1'b0, 1'b0);
        for (int c = 0; c < 1000 && !(mq.size() == 37 && m_valid); c++) step(1'b0, 12'h000, 1'b1, 1'b0);
        n_chk++; if (level_o !== 9'd37) begin n_fail++; $display("FAIL clear_pre_level: got %0d expected 37", level_o); end
        n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL clear_pre_ovf: got %0b expected 1", overflow_o); end
        step(1'b1, 12'h777, 1'b1, 1'b1);
        n_chk++; if (level_o !== 9'd0)    begin n_fail++; $display("FAIL clear_level: got %0d expected 0", level_o); end
        n_chk++; if (r_valid_o !== 1'b0)  begin n_fail++; $display("FAIL clear_valid: got %0b expected 0", r_valid_o); end
        n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: got %0b expected 0", overflow_o); end
        n_chk++; if (empty_o !== 1'b1)    begin n_fail++; $display("FAIL clear_empty: got %0b expected 1", empty_o); end
        step(1'b1, 12'h3C3, 1'b0, 1'b0);
        n_chk++; if (r_valid_o !== 1'b0)  begin n_fail++; $display("FAIL clear_push_e0: got %0b expected 0", r_valid_o); end
        step(1'b0, 12'h000, 1'b0, 1'b0);
        n_chk++; if (r_valid_o !== 1'b0)  begin n_fail++; $display("FAIL clear_push_e1: got %0b expected 0", r_valid_o); end
        step(1'b0, 12'h000, 1'b0, 1'b0);
        n_chk++; if (r_valid_o !== 1'b1)  begin n_fail++; $display("FAIL clear_push_e2: got %0b expected 1", r_valid_o); end
        n_chk++; if (r_data_o !== 12'h3C3) begin n_fail++; $display("FAIL clear_push_data: got %0h expected 3c3", r_data_o); end
        n_chk++; if (level_o !== 9'd1)    begin n_fail++; $display("FAIL clear_push_level: got %0d expected 1", level_o); end
    endtask

    task automatic test_thresholds();
        int n;
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 12'($urandom), 1'b0, 1'b0);
            n_chk++; if (level_o !== 9'(i))                begin n_fail++; $display("FAIL thr_up_level: got %0d expected %0d", level_o, i); end
            n_chk++; if (almost_full_o !== (i >= AFULL))   begin n_fail++; $display("FAIL thr_up_afull@%0d: got %0b expected %0b", i, almost_full_o, (i >= AFULL)); end
            n_chk++; if (almost_empty_o !== (i <= AEMPTY)) begin n_fail++; $display("FAIL thr_up_aempty@%0d: got %0b expected %0b", i, almost_empty_o, (i <= AEMPTY)); end
            n_chk++; if (full_o !== (i == DEPTH))          begin n_fail++; $display("FAIL thr_up_full@%0d: got %0b expected %0b", i, full_o, (i == DEPTH)); end
            n_chk++; if (empty_o !== 1'b0)                 begin n_fail++; $display("FAIL thr_up_empty@%0d: got %0b expected 0", i, empty_o); end
        end
        for (int c = 0; c < 1200 && mq.size() > 0; c++) begin
            step(1'b0, 12'h000, 1'b1, 1'b0);
            n = mq.size();
            n_chk++; if (level_o !== 9'(n))                begin n_fail++; $display("FAIL thr_dn_level: got %0d expected %0d", level_o, n); end
            n_chk++; if (almost_full_o !== (n >= AFULL))   begin n_fail++; $display("FAIL thr_dn_afull@%0d: got %0b expected %0b", n, almost_full_o, (n >= AFULL)); end
            n_chk++; if (almost_empty_o !== (n <= AEMPTY)) begin n_fail++; $display("FAIL thr_dn_aempty@%0d: got %0b expected %0b", n, almost_empty_o, (n <= AEMPTY)); end
            n_chk++; if (empty_o !== (n == 0))             begin n_fail++; $display("FAIL thr_dn_empty@%0d: got %0b expected %0b", n, empty_o, (n == 0)); end
        end
        n_chk++; if (level_o !== 9'd0) begin n_fail++; $display("FAIL thr_drained: got %0d expected 0", level_o); end
    endtask

    initial begin
        rst_i     = 1'b1;
        clear_i   = 1'b0;
        w_en_i    = 1'b0;
        w_data_i  = 12'h000;
        r_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_stream();
        test_clear();
        test_thresholds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
